// File: rtl/relu_pool2_if.sv
// Stream bundle between the convolution filter, relu_pool2 and the next layer.
// Handshake: in_valid qualifies d_in for exactly one beat and there is no ready (the sink always
// accepts); out_valid is a one-cycle pulse qualifying d_out, which holds its value between pulses.
interface relu_pool2_if #(
  parameter int data_width = 16,
  parameter int in_width   = 36
);
  logic [in_width-1:0]   d_in;
  logic                  in_valid;
  logic [data_width-1:0] d_out;
  logic                  out_valid;
  logic                  frame_done;

  modport master (output d_in, in_valid, input d_out, out_valid, frame_done);
  modport slave  (input d_in, in_valid, output d_out, out_valid, frame_done);
endinterface

// File: rtl/relu_pool2.sv
// ReLU + round/shift/saturate requantisation + non-overlapping 2x2 max pooling.
// Two registered stages: requantised pixel, then pooled output.
module relu_pool2 #(
  parameter int data_width = 16,
  parameter int w_width    = 16,
  parameter int FMAP_W     = 24,
  parameter int FMAP_H     = 24,
  parameter int SHIFT      = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  relu_pool2_if.slave bus
);
  localparam int IN_W = w_width + data_width + 4;
  localparam int CW   = $clog2(FMAP_W);
  localparam int RW   = $clog2(FMAP_H);
  localparam int HW   = (FMAP_W > 2) ? $clog2(FMAP_W / 2) : 1;

  localparam logic [IN_W:0] RND  = (SHIFT == 0) ? '0
                                 : ((IN_W+1)'(1) << ((SHIFT > 0) ? (SHIFT - 1) : 0));
  localparam logic [IN_W:0] MAXQ = {{(IN_W+2-data_width){1'b0}}, {(data_width-1){1'b1}}};

  // Stage 1: requantisation
  logic [IN_W:0]         rnd_sum;
  logic [IN_W:0]         shifted;
  logic [data_width-1:0] q_next;
  logic                  s1_valid;
  logic [data_width-1:0] s1_q;

  // One extra bit keeps the rounding add from overflowing; only positive inputs reach it.
  always_comb begin
    rnd_sum = {bus.d_in[IN_W-1], bus.d_in} + RND;
    shifted = rnd_sum >> SHIFT;
    q_next  = '0;
    if (!bus.d_in[IN_W-1] && (bus.d_in != '0)) begin
      if (shifted > MAXQ) q_next = MAXQ[data_width-1:0];
      else                q_next = shifted[data_width-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) s1_q <= q_next;
    end
  end

  // Stage 2: position tracking and pooling
  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic [HW-1:0]         col_half;
  logic [data_width-1:0] h;
  logic [data_width-1:0] line_buf [FMAP_W/2];
  logic [data_width-1:0] buf_rd;
  logic [data_width-1:0] h_q_max;
  logic [data_width-1:0] buf_q_max;
  logic                  last_col;
  logic                  last_row;

  assign col_half  = HW'(col >> 1);
  assign last_col  = (col == CW'(FMAP_W - 1));
  assign last_row  = (row == RW'(FMAP_H - 1));
  assign buf_rd    = line_buf[col_half];
  assign h_q_max   = (h > s1_q) ? h : s1_q;
  assign buf_q_max = (buf_rd > s1_q) ? buf_rd : s1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (s1_valid) begin
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Every entry is written on an even row before the odd row reads it, so no reset is needed.
  always_ff @(posedge clk) begin
    if (s1_valid && !row[0] && col[0]) line_buf[col_half] <= h_q_max;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h              <= '0;
      bus.d_out      <= '0;
      bus.out_valid  <= 1'b0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.out_valid  <= 1'b0;
      bus.frame_done <= 1'b0;
      if (s1_valid) begin
        case ({row[0], col[0]})
          2'b00: h <= s1_q;
          2'b10: h <= buf_q_max;
          2'b11: begin
            bus.d_out      <= h_q_max;
            bus.out_valid  <= 1'b1;
            bus.frame_done <= last_row && last_col;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_relu_pool2.sv
// Bench for relu_pool2: a 4x2 instance for directed cases and a 24x24 instance for the full frame,
// both checked cycle by cycle against a frame-level model.
module tb_relu_pool2;
  localparam int DW   = 16;
  localparam int WW   = 16;
  localparam int IN_W = WW + DW + 4;
  localparam int SH   = 15;
  localparam longint QMAX = (longint'(1) << (DW - 1)) - 1;

  // clock / reset
  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  longint cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  relu_pool2_if #(.data_width(DW), .in_width(IN_W)) if_s ();
  relu_pool2_if #(.data_width(DW), .in_width(IN_W)) if_f ();

  relu_pool2 #(.data_width(DW), .w_width(WW), .FMAP_W(4), .FMAP_H(2), .SHIFT(SH)) dut_s (
    .clk(clk), .rst_n(rst_n), .bus(if_s));
  relu_pool2 #(.data_width(DW), .w_width(WW), .FMAP_W(24), .FMAP_H(24), .SHIFT(SH)) dut_f (
    .clk(clk), .rst_n(rst_n), .bus(if_f));

  // scoreboard state
  typedef struct {
    logic [DW-1:0] d;
    logic          fd;
    longint        due;
  } exp_t;

  exp_t          exp_q_s[$];
  exp_t          exp_q_f[$];
  logic [DW-1:0] obs_s[$];
  int            n_out_f = 0;
  int            n_fd_f  = 0;
  int            n_pass  = 0;
  int            n_total = 0;

  // frame-level model: store every requantised pixel, pool whole 2x2 blocks when complete
  int pix [2][24][24];
  int mrow [2];
  int mcol [2];
  int fw [2] = '{4, 24};
  int fh [2] = '{2, 24};

  task automatic check(input string name, input longint got, input longint exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
  endtask

  function automatic longint requant(input longint x);
    longint r;
    if (x <= 0) return 0;
    r = (x + (longint'(1) << (SH - 1))) / (longint'(1) << SH);
    return (r > QMAX) ? QMAX : r;
  endfunction

  task automatic model_push(input int sel, input longint x);
    int   r;
    int   c;
    int   m;
    exp_t e;
    r = mrow[sel];
    c = mcol[sel];
    pix[sel][r][c] = int'(requant(x));
    if ((r % 2 == 1) && (c % 2 == 1)) begin
      m = pix[sel][r-1][c-1];
      if (pix[sel][r-1][c] > m) m = pix[sel][r-1][c];
      if (pix[sel][r][c-1] > m) m = pix[sel][r][c-1];
      if (pix[sel][r][c]   > m) m = pix[sel][r][c];
      e.d   = DW'(m);
      e.fd  = (r == fh[sel] - 1) && (c == fw[sel] - 1);
      e.due = cyc + 2;
      if (sel == 0) exp_q_s.push_back(e);
      else          exp_q_f.push_back(e);
    end
    c++;
    if (c == fw[sel]) begin
      c = 0;
      r = (r == fh[sel] - 1) ? 0 : r + 1;
    end
    mrow[sel] = r;
    mcol[sel] = c;
  endtask

  // driver tasks
  task automatic drive(input int sel, input longint x);
    @(posedge clk);
    #1;
    if_s.in_valid = (sel == 0);
    if_f.in_valid = (sel == 1);
    if_s.d_in     = (sel == 0) ? IN_W'(x) : '0;
    if_f.d_in     = (sel == 1) ? IN_W'(x) : '0;
    model_push(sel, x);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if_s.in_valid = 1'b0;
      if_f.in_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    if_s.in_valid = 1'b0;
    if_f.in_valid = 1'b0;
    rst_n = 1'b0;
    mrow = '{0, 0};
    mcol = '{0, 0};
    exp_q_s.delete();
    exp_q_f.delete();
    #2;
    check("rst_d_out_s", if_s.d_out, 0);
    check("rst_valid_s", if_s.out_valid, 0);
    check("rst_fd_s", if_s.frame_done, 0);
    check("rst_d_out_f", if_f.d_out, 0);
    check("rst_valid_f", if_f.out_valid, 0);
    check("rst_fd_f", if_f.frame_done, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic flush(input string name);
    idle(5);
    check({name, "_pending"}, exp_q_s.size() + exp_q_f.size(), 0);
  endtask

  task automatic check_obs(input string name, input int exp[$]);
    check({name, "_count"}, obs_s.size(), exp.size());
    for (int i = 0; i < exp.size() && i < obs_s.size(); i++)
      check($sformatf("%s_out%0d", name, i), obs_s[i], exp[i]);
  endtask

  // compare process: every out_valid must match the head of the expected queue, on time
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (if_s.out_valid) begin
        obs_s.push_back(if_s.d_out);
        if (exp_q_s.size() == 0) check("s_extra_pulse", 1, 0);
        else begin
          e = exp_q_s.pop_front();
          check("s_d_out", if_s.d_out, e.d);
          check("s_frame_done", if_s.frame_done, e.fd);
          check("s_latency", cyc, e.due);
        end
      end else if (if_s.frame_done) check("s_fd_stray", 1, 0);
      while (exp_q_s.size() > 0 && exp_q_s[0].due < cyc) begin
        check("s_missing_pulse", 0, 1);
        void'(exp_q_s.pop_front());
      end

      if (if_f.out_valid) begin
        n_out_f++;
        if (if_f.frame_done) n_fd_f++;
        if (exp_q_f.size() == 0) check("f_extra_pulse", 1, 0);
        else begin
          e = exp_q_f.pop_front();
          check("f_d_out", if_f.d_out, e.d);
          check("f_frame_done", if_f.frame_done, e.fd);
          check("f_latency", cyc, e.due);
        end
      end else if (if_f.frame_done) check("f_fd_stray", 1, 0);
      while (exp_q_f.size() > 0 && exp_q_f[0].due < cyc) begin
        check("f_missing_pulse", 0, 1);
        void'(exp_q_f.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  // stimulus
  initial begin
    int     pool_q [8] = '{1, 7, 2, 3, 5, 4, 9, 0};
    longint rq_in  [5];
    int     exp_a[$];
    longint v;

    rq_in = '{98304, -5, (5 <<< 15) + 16384, (5 <<< 15) + 16383, 40000 <<< 15};
    if_s.in_valid = 1'b0;
    if_f.in_valid = 1'b0;
    if_s.d_in = '0;
    if_f.d_in = '0;
    mrow = '{0, 0};
    mcol = '{0, 0};

    #3;
    check("init_d_out_s", if_s.d_out, 0);
    check("init_valid_s", if_s.out_valid, 0);
    check("init_fd_s", if_s.frame_done, 0);
    check("init_d_out_f", if_f.d_out, 0);
    check("init_valid_f", if_f.out_valid, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // pin the model with hand-computed requantisation values
    check("model_rq_98304", requant(rq_in[0]), 3);
    check("model_rq_neg", requant(rq_in[1]), 0);
    check("model_rq_round_up", requant(rq_in[2]), 6);
    check("model_rq_round_dn", requant(rq_in[3]), 5);
    check("model_rq_sat", requant(rq_in[4]), 32767);

    // requantisation: each value fills a whole 4x2 frame
    obs_s.delete();
    for (int k = 0; k < 5; k++)
      for (int i = 0; i < 8; i++) drive(0, rq_in[k]);
    flush("requant");
    exp_a = '{3, 3, 0, 0, 6, 6, 5, 5, 32767, 32767};
    check_obs("requant", exp_a);

    // pooling back-to-back
    obs_s.delete();
    for (int i = 0; i < 8; i++) drive(0, longint'(pool_q[i]) <<< SH);
    flush("pool");
    exp_a = '{7, 9};
    check_obs("pool", exp_a);

    // same stream with random gaps
    obs_s.delete();
    for (int i = 0; i < 8; i++) begin
      drive(0, longint'(pool_q[i]) <<< SH);
      idle($urandom_range(0, 5));
    end
    flush("gaps");
    check_obs("gaps", exp_a);

    // two frames without a bubble
    obs_s.delete();
    for (int i = 0; i < 8; i++) drive(0, longint'(pool_q[i]) <<< SH);
    for (int i = 0; i < 8; i++) drive(0, (i == 6) ? (longint'(100) <<< SH) : 0);
    flush("two_frames");
    exp_a = '{7, 9, 0, 100};
    check_obs("two_frames", exp_a);

    // reset mid-frame, then a clean frame
    obs_s.delete();
    for (int i = 0; i < 3; i++) drive(0, longint'(pool_q[7 - i]) <<< SH);
    do_reset();
    for (int i = 0; i < 8; i++) drive(0, longint'(pool_q[i]) <<< SH);
    flush("mid_reset");
    exp_a = '{7, 9};
    check_obs("mid_reset", exp_a);

    // full-size frame with random signed inputs
    n_out_f = 0;
    n_fd_f  = 0;
    for (int i = 0; i < 24 * 24; i++) begin
      v = longint'($urandom_range(0, 2000000)) - 1000000;
      case ($urandom_range(0, 3))
        0:       v = v;
        1:       v = v * 1000;
        2:       v = v * 20000;
        default: v = v * 16;
      endcase
      drive(1, v);
    end
    flush("full");
    check("full_out_count", n_out_f, 144);
    check("full_fd_count", n_fd_f, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
